shift_serializer: RTL and testbench
===================================

SHIFT_SERIALIZER -- requirements
Module: shift_serializer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, clock cycles per serial bit; legal range 1..255.
REQ-002 SHALL have parameter MSB_FIRST, default 0; 0 = LSB first, 1 = MSB first.
REQ-003 SHALL have parameter PARITY_EN, default 0; 1 inserts an even-parity bit after the data bits.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1, upstream word valid (driven by the barrel shifter's consumer logic).
REQ-007 SHALL have port in_data, input, 8, shifted_data word from the barrel shifter.
REQ-008 SHALL have port in_ready, output, 1, serializer can accept a word.
REQ-009 SHALL have port ser_out, output, 1, registered serial line; idle high.
REQ-010 SHALL have port busy, output, 1, high while a frame is in flight.
REQ-011 SHALL have port done, output, 1, one-cycle pulse marking frame completion.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-013 SHALL assert in_ready only in IDLE; a transfer occurs on a rising edge with in_valid && in_ready.
REQ-014 SHALL latch in_data into an internal 8-bit shift register on transfer and enter START on that edge.
REQ-015 SHALL ignore in_valid and in_data while not in IDLE; the latched word is never modified mid-frame.
REQ-016 SHALL drive ser_out = 0 in START, the current data bit in DATA, the parity bit in PARITY, and 1 in STOP and IDLE.
REQ-017 SHALL hold every bit for exactly CLKS_PER_BIT cycles using a down-counter reloaded to CLKS_PER_BIT-1 at each bit boundary.
REQ-018 SHALL send 8 data bits in DATA, tracked by a 3-bit index; DATA exits when index = 7 and the bit timer expires.
REQ-019 SHALL order bits by MSB_FIRST: LSB first (bit 0..7) when 0, bit 7..0 when 1.
REQ-020 SHALL compute parity as the XOR of the latched 8 bits; the PARITY state is skipped entirely when PARITY_EN = 0.
REQ-021 SHALL make the frame length (10 + PARITY_EN) * CLKS_PER_BIT cycles, measured from the first START cycle to the last STOP cycle.
REQ-022 SHALL pulse done high during the last STOP cycle only, then enter IDLE.
REQ-023 SHALL drive busy = 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-024 SHALL accept a back-to-back word (in_valid held high) on the first IDLE cycle, giving exactly one idle-high cycle between frames.
REQ-025 SHALL behave correctly at CLKS_PER_BIT = 1, one cycle per bit with no counter underflow.

Reset
REQ-026 SHALL, while rst_n = 0, force asynchronously: state = IDLE, ser_out = 1, in_ready = 0, busy = 0, done = 0, shift register = 0, counters = 0.
REQ-027 SHALL abort any frame in progress on reset; no partial-frame resumption after release.
REQ-028 SHALL raise in_ready in the first cycle after rst_n deasserts.

Structure
REQ-029 SHALL keep the FSM state enum and the default CLKS_PER_BIT constant in a shared package, shift_pkg.
REQ-030 SHALL put the bit-period counter in one sub-module, bit_timer, which outputs a tick on expiry and has a reload input.
REQ-031 SHALL keep the module at roughly 120-400 lines of RTL.

Verification
REQ-032 SHALL check: CLKS_PER_BIT=4, send 8'hA5 -> ser_out 0,1,0,1,0,0,1,0,1,1 at 4 cycles each; done at cycle 40.
REQ-033 SHALL check: MSB_FIRST=1, send 8'h80 -> ser_out 0,1,0,0,0,0,0,0,0,1.
REQ-034 SHALL check: PARITY_EN=1, send 8'h07 -> parity bit 1; frame 44 cycles at CLKS_PER_BIT=4.
REQ-035 SHALL check: 8'h01 then 8'hFE with in_valid held high -> second start bit begins 1 cycle after the first done.
REQ-036 SHALL check: rst_n pulsed low during data bit 3 -> ser_out=1, busy=0 immediately; after release, 8'h3C frames correctly.
REQ-037 SHALL check: in_data changed to 8'hFF mid-frame with in_valid=1 -> in_ready=0 and the transmitted word is unchanged.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and constants for the shift serializer.
//   ser_state_e : frame FSM states
//   ser_out_t   : registered output bundle (serial line + handshake/status)
//   helpers     : even parity of a word, data-bit selection by order
package shift_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 4;
    localparam int unsigned DATA_W               = 8;
    localparam int unsigned IDX_W                = 3;
    localparam int unsigned CNT_W                = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } ser_state_e;

    typedef struct packed {
        logic ser;
        logic busy;
        logic done;
        logic ready;
    } ser_out_t;

    // Line idles high; in_ready stays low until the first clock after reset.
    localparam ser_out_t OUT_RESET = '{ser: 1'b1, busy: 1'b0, done: 1'b0, ready: 1'b0};

    // Even parity bit: makes the total count of ones (data + parity) even.
    function automatic logic even_parity(input logic [DATA_W-1:0] word);
        return ^word;
    endfunction

    // Data bit sent at position idx of the DATA phase.
    function automatic logic pick_bit(input logic [DATA_W-1:0] word,
                                      input logic [IDX_W-1:0]  idx,
                                      input logic              msb_first);
        logic [IDX_W-1:0] pos;
        pos = msb_first ? IDX_W'(IDX_W'(DATA_W - 1) - idx) : idx;
        return word[pos];
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period down-counter.
//   clk, rst_n  : clock, async active-low reset (count cleared to 0)
//   reload      : load CLKS_PER_BIT-1 at a bit boundary
//   tick_c      : count is 0, the current bit period ends this cycle
//   tick_next_c : count will be 0 in the next cycle
module bit_timer
    import shift_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reload,
    output logic tick_c,
    output logic tick_next_c
);

    localparam logic [CNT_W-1:0] RELOAD_VAL = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count down and park at zero; never wraps, so CLKS_PER_BIT=1 ticks every cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (reload) begin
            cnt_d = RELOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = CNT_W'(cnt_q - 1'b1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_c      = (cnt_q == '0);
    assign tick_next_c = (cnt_d == '0);

endmodule

// File: rtl/shift_serializer.sv
// Byte-to-serial frame generator: start bit (0), 8 data bits, optional even
// parity bit, stop bit (1). Each bit lasts CLKS_PER_BIT clocks.
//   clk, rst_n : clock, async active-low reset (aborts any frame)
//   in_valid   : upstream word valid
//   in_data    : word to send, latched on in_valid && in_ready
//   in_ready   : high only while idle
//   ser_out    : registered serial line, idle high
//   busy       : high while a frame is in flight
//   done       : one-cycle pulse during the last stop-bit cycle
module shift_serializer
    import shift_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned MSB_FIRST    = 0,
    parameter int unsigned PARITY_EN    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              ser_out,
    output logic              busy,
    output logic              done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
    localparam logic             MSB_SEL  = (MSB_FIRST != 0);
    localparam logic             PAR_SEL  = (PARITY_EN != 0);

    ser_state_e        state_q;
    ser_state_e        state_d;
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] word_d;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_d;
    ser_out_t          out_q;
    ser_out_t          out_d;

    logic take_c;
    logic reload_c;
    logic tick_c;
    logic tick_next_c;

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .reload      (reload_c),
        .tick_c      (tick_c),
        .tick_next_c (tick_next_c)
    );

    // Handshake uses the registered ready, which is only high in IDLE.
    assign take_c = in_valid && out_q.ready;

    // Next-state, latched word, bit index, timer reload and next outputs.
    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        idx_d    = idx_q;
        reload_c = 1'b0;
        out_d    = OUT_RESET;

        case (state_q)
            ST_IDLE: begin
                if (take_c) begin
                    state_d  = ST_START;
                    word_d   = in_data;
                    idx_d    = '0;
                    reload_c = 1'b1;
                end
            end
            ST_START: begin
                if (tick_c) begin
                    state_d  = ST_DATA;
                    idx_d    = '0;
                    reload_c = 1'b1;
                end
            end
            ST_DATA: begin
                if (tick_c) begin
                    reload_c = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = PAR_SEL ? ST_PARITY : ST_STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d = IDX_W'(idx_q + 1'b1);
                    end
                end
            end
            ST_PARITY: begin
                if (tick_c) begin
                    state_d  = ST_STOP;
                    reload_c = 1'b1;
                end
            end
            ST_STOP: begin
                // No reload on exit: the timer parks at zero while idle.
                if (tick_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        case (state_d)
            ST_START:  out_d.ser = 1'b0;
            ST_DATA:   out_d.ser = pick_bit(word_d, idx_d, MSB_SEL);
            ST_PARITY: out_d.ser = even_parity(word_d);
            default:   out_d.ser = 1'b1;
        endcase
        out_d.busy  = (state_d != ST_IDLE);
        out_d.ready = (state_d == ST_IDLE);
        // The stop cycle whose timer reads zero is the last one of the frame.
        out_d.done  = (state_d == ST_STOP) && tick_next_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            out_q   <= OUT_RESET;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
        end
    end

    assign in_ready = out_q.ready;
    assign ser_out  = out_q.ser;
    assign busy     = out_q.busy;
    assign done     = out_q.done;

endmodule

// File: tb/tb_shift_serializer.sv
// Bench for shift_serializer: four configurations side by side, a per-cycle
// frame model built from queued expected line levels, and directed frames
// with literal expected bit patterns.
module tb_shift_serializer;

    localparam int NDUT = 4;
    localparam int CPB [NDUT] = '{4, 4, 4, 1};
    localparam bit MSB [NDUT] = '{1'b0, 1'b1, 1'b0, 1'b1};
    localparam bit PAR [NDUT] = '{1'b0, 1'b0, 1'b1, 1'b1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NDUT-1:0] in_valid = '0;
    logic [NDUT-1:0] in_ready;
    logic [NDUT-1:0] ser_out;
    logic [NDUT-1:0] busy;
    logic [NDUT-1:0] done;
    logic [7:0] in_data [NDUT];

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    shift_serializer #(.CLKS_PER_BIT(4), .MSB_FIRST(0), .PARITY_EN(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_data(in_data[0]),
        .in_ready(in_ready[0]), .ser_out(ser_out[0]), .busy(busy[0]), .done(done[0]));
    shift_serializer #(.CLKS_PER_BIT(4), .MSB_FIRST(1), .PARITY_EN(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_data(in_data[1]),
        .in_ready(in_ready[1]), .ser_out(ser_out[1]), .busy(busy[1]), .done(done[1]));
    shift_serializer #(.CLKS_PER_BIT(4), .MSB_FIRST(0), .PARITY_EN(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_data(in_data[2]),
        .in_ready(in_ready[2]), .ser_out(ser_out[2]), .busy(busy[2]), .done(done[2]));
    shift_serializer #(.CLKS_PER_BIT(1), .MSB_FIRST(1), .PARITY_EN(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_data(in_data[3]),
        .in_ready(in_ready[3]), .ser_out(ser_out[3]), .busy(busy[3]), .done(done[3]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: on acceptance, queue the whole frame as {line level, done} per cycle.
    logic [1:0] exp_q [NDUT][$];
    logic [NDUT-1:0] m_ser = '1;
    logic [NDUT-1:0] m_busy = '0;
    logic [NDUT-1:0] m_done = '0;
    logic [NDUT-1:0] m_ready = '0;
    logic [7:0] md;
    logic frame_bits [11];
    int nb;
    logic [1:0] e;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NDUT; k++) begin
                exp_q[k].delete();
                m_ser[k] = 1'b1;
                m_busy[k] = 1'b0;
                m_done[k] = 1'b0;
                m_ready[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < NDUT; k++) begin
                if (in_valid[k] && m_ready[k]) begin
                    md = in_data[k];
                    frame_bits[0] = 1'b0;
                    for (int i = 0; i < 8; i++) begin
                        frame_bits[1 + i] = MSB[k] ? md[7 - i] : md[i];
                    end
                    nb = 9;
                    if (PAR[k]) begin
                        frame_bits[nb] = ^md;
                        nb++;
                    end
                    frame_bits[nb] = 1'b1;
                    nb++;
                    for (int b = 0; b < nb; b++) begin
                        for (int r = 0; r < CPB[k]; r++) begin
                            exp_q[k].push_back({frame_bits[b], (b == nb - 1) && (r == CPB[k] - 1)});
                        end
                    end
                end
                if (exp_q[k].size() > 0) begin
                    e = exp_q[k].pop_front();
                    m_ser[k] = e[1];
                    m_done[k] = e[0];
                    m_busy[k] = 1'b1;
                    m_ready[k] = 1'b0;
                end else begin
                    m_ser[k] = 1'b1;
                    m_done[k] = 1'b0;
                    m_busy[k] = 1'b0;
                    m_ready[k] = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison of every DUT against the model.
    always @(negedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("ser_out[%0d]", k), 32'(ser_out[k]), 32'(m_ser[k]));
            check($sformatf("busy[%0d]", k), 32'(busy[k]), 32'(m_busy[k]));
            check($sformatf("done[%0d]", k), 32'(done[k]), 32'(m_done[k]));
            check($sformatf("in_ready[%0d]", k), 32'(in_ready[k]), 32'(m_ready[k]));
        end
    end

    // Raise valid; returns at the negedge of the first START cycle.
    task automatic start(input int k, input logic [7:0] d);
        @(negedge clk);
        in_data[k] = d;
        in_valid[k] = 1'b1;
        @(negedge clk);
    endtask

    // Sample mid-bit levels until done; optionally change data / drop valid mid-frame.
    task automatic capture(input int k, input logic [7:0] chg_data, input int chg_at,
                           input int drop_at, output logic [10:0] bits, output int len,
                           output logic ready_seen);
        bits = '0;
        len = 0;
        ready_seen = 1'b0;
        for (int c = 0; c < 400; c++) begin
            len = c + 1;
            if ((c % CPB[k]) == (CPB[k] / 2)) bits[4'(c / CPB[k])] = ser_out[k];
            ready_seen = ready_seen | in_ready[k];
            if (len == chg_at) in_data[k] = chg_data;
            if (len == drop_at) in_valid[k] = 1'b0;
            if (done[k]) return;
            @(negedge clk);
        end
        n_checks++;
        n_fail++;
        $display("FAIL capture_timeout[%0d]: got no done, expected done within 400 cycles", k);
    endtask

    logic [10:0] bits;
    int len;
    logic rs;
    int gap;

    initial begin
        for (int k = 0; k < NDUT; k++) in_data[k] = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ser", 32'(ser_out[0]), 32'h1);
        check("rst_busy", 32'(busy[0]), 32'h0);
        check("rst_ready", 32'(in_ready[0]), 32'h0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(in_ready[0]), 32'h1);

        // 8'hA5 LSB first: 0,1,0,1,0,0,1,0,1,1
        start(0, 8'hA5);
        capture(0, 8'h00, 0, 1, bits, len, rs);
        check("a5_bits", 32'(bits), 32'h34A);
        check("a5_len", 32'(len), 32'd40);

        // 8'h80 MSB first: 0,1,0,0,0,0,0,0,0,1
        start(1, 8'h80);
        capture(1, 8'h00, 0, 1, bits, len, rs);
        check("80_msb_bits", 32'(bits), 32'h202);
        check("80_msb_len", 32'(len), 32'd40);

        // 8'h07 with parity: parity bit 1, 44-cycle frame
        start(2, 8'h07);
        capture(2, 8'h00, 0, 1, bits, len, rs);
        check("07_par_bits", 32'(bits), 32'h60E);
        check("07_par_bit", 32'(bits[9]), 32'h1);
        check("07_par_len", 32'(len), 32'd44);

        // CLKS_PER_BIT=1, MSB first, parity: 8'hB2 -> 11-cycle frame
        start(3, 8'hB2);
        capture(3, 8'h00, 0, 1, bits, len, rs);
        check("b2_cpb1_bits", 32'(bits), 32'h49A);
        check("b2_cpb1_len", 32'(len), 32'd11);

        // Back-to-back 8'h01 then 8'hFE with valid held high
        start(0, 8'h01);
        capture(0, 8'hFE, 1, 0, bits, len, rs);
        check("b2b_first_bits", 32'(bits), 32'h202);
        check("b2b_first_ready", 32'(rs), 32'h0);
        gap = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            gap++;
            if (ser_out[0] == 1'b0) break;
        end
        check("b2b_gap", 32'(gap), 32'd2);
        in_valid[0] = 1'b0;
        capture(0, 8'h00, 0, 0, bits, len, rs);
        check("b2b_second_bits", 32'(bits), 32'h3FC);
        check("b2b_second_len", 32'(len), 32'd40);

        // Mid-frame data change to 8'hFF with valid high: word stays 8'h5A
        start(0, 8'h5A);
        capture(0, 8'hFF, 5, 20, bits, len, rs);
        check("midchg_bits", 32'(bits), 32'h2B4);
        check("midchg_ready", 32'(rs), 32'h0);

        // Reset during data bit 3 of 8'hC3, then send 8'h3C
        start(0, 8'hC3);
        in_valid[0] = 1'b0;
        repeat (17) @(negedge clk);
        check("c3_bit3", 32'(ser_out[0]), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ser", 32'(ser_out[0]), 32'h1);
        check("abort_busy", 32'(busy[0]), 32'h0);
        check("abort_ready", 32'(in_ready[0]), 32'h0);
        check("abort_done", 32'(done[0]), 32'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_abort", 32'(in_ready[0]), 32'h1);
        start(0, 8'h3C);
        capture(0, 8'h00, 0, 1, bits, len, rs);
        check("3c_bits", 32'(bits), 32'h278);
        check("3c_len", 32'(len), 32'd40);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected end of test before t=200000");
        $fatal(1, "watchdog expired");
    end

endmodule
